// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request port.
// Each request completes after a fixed LATENCY and returns one response pulse.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap_en;
  logic          acc_en;
  logic          req_err_c;

  logic          wr_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          acc_write;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;

  logic [31:0]   mem [DEPTH_WORDS];

  // Misaligned or beyond the last stored word
  assign req_err_c = (addr_i[1:0] != 2'b00) || ((addr_i >> (AW + 2)) != 32'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          cap_en = 1'b1;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            acc_en  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_RESP;
          acc_en  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle latency accesses straight from the request; longer ones use the capture
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write_i;
      acc_err   = req_err_c;
      acc_idx   = addr_i[AW+1:2];
      acc_wdata = wdata_i;
    end else begin
      acc_write = wr_q;
      acc_err   = err_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (cap_en) begin
        wr_q    <= req_write_i;
        err_q   <= req_err_c;
        idx_q   <= addr_i[AW+1:2];
        wdata_q <= wdata_i;
      end
      if (acc_en) begin
        err_o   <= acc_err;
        rdata_o <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (acc_en && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench: one responder at LATENCY=2 and one at LATENCY=1,
// checked against a plain array model of the memory and its error rules.
module tb_dmem_responder;

  localparam int unsigned NDUT = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_write [NDUT];
  logic [31:0] addr      [NDUT];
  logic [31:0] wdata     [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rdata     [NDUT];
  logic        err       [NDUT];
  logic        busy      [NDUT];

  logic [31:0] model [NDUT][32];
  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        me;
  bit          rdy_next [NDUT];

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(32),
      .LATENCY((g == 0) ? 2 : 1)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_write_i(req_write[g]),
      .addr_i     (addr[g]),
      .wdata_i    (wdata[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rdata_o    (rdata[g]),
      .err_o      (err[g]),
      .busy_o     (busy[g])
    );
  end

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic void sb_push(input int k, input exp_t e);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_pop(input int k);
    if (k == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  task automatic model_clear(input int k);
    for (int w = 0; w < 32; w++) model[k][w] = 32'd0;
  endtask

  // Present a request, hold it until ready, then record what the memory should answer
  task automatic issue(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int unsigned acc);
    int   guard;
    exp_t e;
    logic is_err;
    int   w;
    guard = 0;
    acc   = 0;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    addr[k]      = a;
    wdata[k]     = d;
    while (!req_ready[k]) begin
      if (guard == 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout dut%0d: ready still 0 after %0d cycles, expected 1", k, guard);
        req_valid[k] = 1'b0;
        return;
      end
      guard++;
      @(negedge clk);
    end
    acc    = cyc;
    is_err = (a % 4 != 0) || (a >= 32'd128);
    w      = int'(a / 4) % 32;
    e.err   = is_err;
    e.cyc   = acc + lat(k);
    e.rdata = (is_err || wr) ? 32'd0 : model[k][w];
    if (!is_err && wr) model[k][w] = d;
    sb_push(k, e);
  endtask

  task automatic req(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned t;
    issue(k, wr, a, d, t);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid[k] = 1'b0;
    end
  endtask

  // Monitor: every response is popped against the scoreboard, including its arrival cycle
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      chk("busy_vs_ready", k, 32'(busy[k]), 32'(!req_ready[k]));
      if (rdy_next[k]) begin
        chk("ready_after_rsp", k, 32'(req_ready[k]), 32'd1);
        chk("rsp_one_cycle", k, 32'(rsp_valid[k]), 32'd0);
        rdy_next[k] = 1'b0;
      end
      if (rsp_valid[k]) begin
        rdy_next[k] = 1'b1;
        chk("ready_in_rsp", k, 32'(req_ready[k]), 32'd0);
        if (sb_size(k) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1, expected no response (cycle %0d)", k, cyc);
        end else begin
          me = sb_pop(k);
          chk("rsp_rdata", k, rdata[k], me.rdata);
          chk("rsp_err", k, 32'(err[k]), 32'(me.err));
          chk("rsp_cycle", k, cyc, me.cyc);
        end
      end
    end
  end

  initial begin
    int unsigned t0;
    int unsigned t1;
    int          g;
    for (int k = 0; k < NDUT; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b1;
      req_write[k] = 1'b0;
      addr[k]      = 32'h10;
      wdata[k]     = 32'd0;
      model_clear(k);
    end

    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        chk("rst_ready", k, 32'(req_ready[k]), 32'd1);
        chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
        chk("rst_rdata", k, rdata[k], 32'd0);
        chk("rst_err", k, 32'(err[k]), 32'd0);
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      rst[k]       = 1'b0;
      req_valid[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("post_rst_ready", k, 32'(req_ready[k]), 32'd1);
      chk("post_rst_busy", k, 32'(busy[k]), 32'd0);
    end

    // Directed round trip, error cases, busy hold and back-to-back spacing
    for (int k = 0; k < NDUT; k++) begin
      req(k, 1'b1, 32'h10, 32'hDEADBEEF);
      idle(k, 4);
      req(k, 1'b0, 32'h10, 32'd0);
      req(k, 1'b1, 32'h13, 32'h5555AAAA);
      req(k, 1'b1, 32'h80, 32'h00001234);
      req(k, 1'b0, 32'h10, 32'd0);
      req(k, 1'b0, 32'h00, 32'd0);
      req(k, 1'b1, 32'h20, 32'h0BADF00D);
      req(k, 1'b0, 32'h10, 32'd0);
      req(k, 1'b0, 32'h20, 32'd0);
      idle(k, 2);
      issue(k, 1'b0, 32'h20, 32'd0, t0);
      for (int j = 0; j < 3; j++) begin
        issue(k, 1'b0, 32'(4 * j), 32'd0, t1);
        chk("accept_spacing", k, t1 - t0, lat(k) + 1);
        t0 = t1;
      end
      idle(k, 4);
    end

    // Randomized traffic with a mix of legal, misaligned and out-of-range addresses
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 80; i++) begin
        logic [31:0] a;
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        else if (sel < 8)  a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        else if (sel == 8) a = 32'($urandom_range(128, 4095));
        else               a = $urandom;
        req(k, 1'($urandom_range(0, 1)), a, $urandom);
        if ($urandom_range(0, 3) == 0) idle(k, int'($urandom_range(1, 3)));
      end
      idle(k, 4);
    end

    // Reset during WAIT discards the store and wipes the array
    req(0, 1'b1, 32'h04, 32'hCAFEF00D);
    @(negedge clk);
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'd1);
    rst[0]       = 1'b1;
    req_valid[0] = 1'b0;
    sb0.delete();
    model_clear(0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (4) @(negedge clk);
    req(0, 1'b0, 32'h04, 32'd0);
    req(0, 1'b0, 32'h10, 32'd0);
    idle(0, 4);

    g = 0;
    while ((sb_size(0) != 0 || sb_size(1) != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g == 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses still pending, expected 0", sb_size(0) + sb_size(1));
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that sits on the far side of the CPU's MEM-stage load/store port. It accepts one word-aligned read or write request through a valid/ready handshake. It services the request after a fixed, parameterised latency and returns a one-cycle response carrying read data and an error flag. The pipeline holds its MEM stage while `req_ready_o` is low, which lets the team model slow memory behind the existing pipeline.

## Interface
- `DEPTH_WORDS`, default 32: number of 32-bit words stored; must be a power of two, ≥ 2.
- `LATENCY`, default 2: cycles from request acceptance to response; legal range 1–15.

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `req_valid_i`  input  1  request present.
- `req_ready_o`  output  1  responder can accept a request this cycle.
- `req_write_i`  input  1  1 = store, 0 = load; sampled on acceptance.
- `addr_i`  input  32  byte address; sampled on acceptance.
- `wdata_i`  input  32  store data; sampled on acceptance.
- `rsp_valid_o`  output  1  one-cycle response strobe.
- `rdata_o`  output  32  load data; meaningful only while `rsp_valid_o` is high.
- `err_o`  output  1  request was misaligned or out of range; meaningful only while `rsp_valid_o` is high.
- `busy_o`  output  1  a request is in flight; equals the inverse of `req_ready_o`.

## Operation
- **Storage:** `DEPTH_WORDS` × 32-bit array. Word index = `addr_i[AW+1:2]`, where AW = log2(`DEPTH_WORDS`).
- **Error conditions:**
  - `addr_i[1:0]` ≠ 0 (misaligned), or
  - `addr_i[31:AW+2]` ≠ 0 (out of range).
  - An errored request never writes the array. It returns `rdata_o` = 0 and `err_o` = 1.
- **State machine:** states IDLE, WAIT, RESP.
  - IDLE: `req_ready_o` = 1. When `req_valid_i` = 1, capture `req_write_i`, `addr_i`, `wdata_i` and the error flag, and load the counter with `LATENCY`−1.
    - `LATENCY` = 1: go directly to RESP.
    - Otherwise: go to WAIT.
  - WAIT: decrement the counter each cycle. On the edge where the counter equals 1, go to RESP and perform the access on that edge:
    - store without error: array[idx] ← wdata
    - load without error: `rdata_o` ← array[idx]
    - error: `rdata_o` ← 0
  - For `LATENCY` = 1, the access is performed on the acceptance edge itself.
  - RESP: `rsp_valid_o` = 1 for exactly one cycle, then go to IDLE unconditionally.
- **Stores:** `rdata_o` = 0 in the response.
- **Output registers:** `rdata_o` and `err_o` are registered. They hold their last value until the next response.
- **Requests while busy:** `req_valid_i` is ignored outside IDLE. The requester must hold its request until it sees `req_ready_o` high.
- **Load after store, same word:** a load accepted after a store's response returns the newly stored data.
- **Reset:** clears state to IDLE, the counter, all array words, `rdata_o` and `err_o` to 0. Reset mid-request aborts it: a store still in WAIT is discarded and the array stays zero, and no response is issued.

## Timing
- **Reset values:** `req_ready_o` = 1, `busy_o` = 0, `rsp_valid_o` = 0, `rdata_o` = 0, `err_o` = 0.
- **Latency:** request accepted on edge E. `rsp_valid_o` is high in the cycle after edge E+`LATENCY`−1, i.e. visible `LATENCY` cycles after the acceptance cycle.
- **Ready return:** `req_ready_o` goes high again in the cycle after the RESP cycle.
- **Throughput:** one request per `LATENCY`+1 cycles. There is no back-to-back acceptance during RESP.
- **Combinational paths:** `req_ready_o` and `busy_o` decode from state only. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with `req_valid_i` = 1 -> during reset `req_ready_o` = 1, `rsp_valid_o` = 0, `rdata_o` = 0. No acceptance is counted before release.
- **Store/load round trip (`LATENCY` = 2):**
  - Store 0xDEADBEEF to 0x10, accepted in cycle 0 -> `rsp_valid_o` high in cycle 2 only, `err_o` = 0, `req_ready_o` high in cycle 3.
  - Then load 0x10 -> `rdata_o` = 0xDEADBEEF with `rsp_valid_o`.
- **Errors:**
  - Store to 0x13 -> `err_o` = 1, `rdata_o` = 0.
  - Store 0x1234 to 0x80 (`DEPTH_WORDS` = 32) -> `err_o` = 1.
  - Subsequent loads of 0x10 and 0x00 -> prior contents unchanged.
- **Busy hold:** hold `req_valid_i` high with a different address during WAIT -> not accepted until `req_ready_o` returns. Exactly one response per accepted request, each with the correct data.
- **Reset mid-operation:** store 0xCAFEF00D to 0x04, assert `rst_i` in the WAIT cycle -> no response. A later load of 0x04 returns 0.
- **`LATENCY` = 1:** consecutive loads -> a response every 2 cycles. `busy_o` toggles 1,0 in alternate cycles while `req_valid_i` is held high.
